dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 107 ++++++++++
 tb/tb_dmem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: m0 (core) has priority, m1 (DMA/debug)
// gets a forced grant after losing STARVE_LIMIT consecutive contended cycles.
module dmem_arbiter #(
  parameter int DMEM_DEPTH   = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_data_in,
  output logic        dmem_wen,
  output logic        dmem_ren,
  input  logic [31:0] dmem_data_out
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  localparam logic [31:0] TOP = 32'(DMEM_DEPTH * 4);

  logic [CW-1:0] starve_q, starve_d;
  logic          rvalid0_q, rvalid1_q;
  logic [31:0]   rdata0_q, rdata1_q;
  logic          err0_q, err1_q;

  logic        both, force1, g0, g1, gnt;
  logic        sel_we, legal;
  logic [31:0] sel_addr, sel_wdata, rsp_data;

  assign both   = m0_req & m1_req;
  assign force1 = both & (starve_q == LIM);
  assign g0     = rst_n & m0_req & ~force1;
  assign g1     = rst_n & m1_req & (~m0_req | force1);
  assign gnt    = g0 | g1;

  always_comb begin
    sel_we    = m0_we;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (g1) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  assign legal = (sel_addr[1:0] == 2'b00) & (sel_addr < TOP);

  assign dmem_addr    = gnt ? sel_addr : '0;
  assign dmem_data_in = gnt ? sel_wdata : '0;
  assign dmem_wen     = gnt & legal & sel_we;
  assign dmem_ren     = gnt & legal & ~sel_we;

  assign rsp_data = (legal & ~sel_we) ? dmem_data_out : '0;

  always_comb begin
    starve_d = starve_q;
    if (!m1_req || g1) starve_d = '0;
    else if (both && g0) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      rvalid0_q <= g0;
      rvalid1_q <= g1;
      rdata0_q  <= g0 ? rsp_data : '0;
      rdata1_q  <= g1 ? rsp_data : '0;
      err0_q    <= g0 & ~legal;
      err1_q    <= g1 & ~legal;
    end
  end

  // A response pending across a reset assertion is dropped immediately.
  assign m0_gnt    = g0;
  assign m1_gnt    = g1;
  assign m0_rvalid = rvalid0_q & rst_n;
  assign m1_rvalid = rvalid1_q & rst_n;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign m0_err    = err0_q;
  assign m1_err    = err1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter with a transaction-level reference model
// and a behavioural data memory attached to the dmem port.
module tb_dmem_arbiter;

  localparam int DEPTH = 256;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] dmem_addr, dmem_data_in, dmem_data_out;
  logic        dmem_wen, dmem_ren;

  always #5 clk = ~clk;

  dmem_arbiter #(.DMEM_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dmem_addr(dmem_addr), .dmem_data_in(dmem_data_in),
    .dmem_wen(dmem_wen), .dmem_ren(dmem_ren),
    .dmem_data_out(dmem_data_out)
  );

  // Behavioural memory driven only by the DUT's dmem port
  logic [31:0] mem [DEPTH];
  always_comb begin
    dmem_data_out = '0;
    if (dmem_addr < 32'(DEPTH * 4)) dmem_data_out = mem[dmem_addr[9:2]];
  end
  always @(posedge clk) if (dmem_wen) mem[dmem_addr[9:2]] <= dmem_data_in;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  int          starve;
  bit          e_g0, e_g1;
  bit          exp_rv0, exp_rv1, exp_err0, exp_err1, chk_rd0, chk_rd1;
  logic [31:0] exp_rd0, exp_rd1;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'(DEPTH * 4));
  endfunction

  task automatic step();
    bit          both, g, lg, swe;
    logic [31:0] sa, swd, rsp;
    @(negedge clk);
    both = m0_req && m1_req;
    e_g0 = rst_n && m0_req && !(both && starve == LIMIT);
    e_g1 = rst_n && m1_req && !e_g0;
    g    = e_g0 || e_g1;
    sa   = e_g1 ? m1_addr : m0_addr;
    swd  = e_g1 ? m1_wdata : m0_wdata;
    swe  = e_g1 ? m1_we : m0_we;
    lg   = legal(sa);
    chk("m0_gnt", 32'(m0_gnt), 32'(e_g0));
    chk("m1_gnt", 32'(m1_gnt), 32'(e_g1));
    chk("dmem_addr", dmem_addr, g ? sa : 32'd0);
    chk("dmem_data_in", dmem_data_in, g ? swd : 32'd0);
    chk("dmem_wen", 32'(dmem_wen), 32'(g && lg && swe));
    chk("dmem_ren", 32'(dmem_ren), 32'(g && lg && !swe));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv0 && rst_n));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv1 && rst_n));
    if (chk_rd0) begin
      chk("m0_rdata", m0_rdata, exp_rd0);
      chk("m0_err", 32'(m0_err), 32'(exp_err0));
    end
    if (chk_rd1) begin
      chk("m1_rdata", m1_rdata, exp_rd1);
      chk("m1_err", 32'(m1_err), 32'(exp_err1));
    end
    @(posedge clk);
    if (!rst_n) begin
      starve = 0;
      {exp_rv0, exp_rv1, exp_err0, exp_err1} = '0;
      exp_rd0 = '0;
      exp_rd1 = '0;
      chk_rd0 = 1'b1;
      chk_rd1 = 1'b1;
    end else begin
      if (!m1_req || e_g1) starve = 0;
      else if (both) starve++;
      rsp = (g && lg && !swe) ? ref_mem[sa[9:2]] : 32'd0;
      exp_rv0 = e_g0; exp_rd0 = rsp; exp_err0 = e_g0 && !lg; chk_rd0 = e_g0;
      exp_rv1 = e_g1; exp_rd1 = rsp; exp_err1 = e_g1 && !lg; chk_rd1 = e_g1;
      if (g && lg && swe) ref_mem[sa[9:2]] = swd;
    end
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0: a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      1: a = 32'h400 + $urandom_range(0, 4096);
      2: a = 32'h3FC;
      3: a = 32'h400;
      4: a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      default: a = 32'($urandom_range(0, 15)) << 2;
    endcase
    return a;
  endfunction

  int m1_wins;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    starve = 0;
    {exp_rv0, exp_rv1, exp_err0, exp_err1, chk_rd0, chk_rd1} = '0;
    exp_rd0 = '0;
    exp_rd1 = '0;
    rst_n = 1'b0;
    {m0_req, m0_we, m1_req, m1_we} = '0;
    m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
    step();
    step();
    rst_n = 1'b1;

    // Single read of word 4
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    step();
    m0_req = 1'b0;
    step();

    // m1 write then read-back of the same word
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    step();
    m1_we = 1'b0;
    step();
    m1_req = 1'b0;
    step();

    // Contention: m1 must win every fifth cycle
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8;
    m1_wins = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (e_g1) m1_wins++;
    end
    chk("starve_m1_wins", 32'(m1_wins), 32'd3);
    m0_req = 1'b0; m1_req = 1'b0;
    step();

    // Illegal writes: misaligned, then out of range
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h22; m0_wdata = 32'hA5A5A5A5;
    step();
    m0_addr = 32'h400;
    step();
    m0_req = 1'b0;
    step();

    // Reset arriving the cycle after a grant
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h30;
    step();
    rst_n = 1'b0; m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0;
    step();
    step();
    rst_n = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    step();

    // Randomized traffic; requests are held until granted
    for (int c = 0; c < 3000; c++) begin
      if (!m0_req || e_g0) begin
        m0_req = ($urandom_range(0, 99) < 60);
        m0_we = 1'($urandom);
        m0_addr = rand_addr();
        m0_wdata = $urandom;
      end
      if (!m1_req || e_g1) begin
        m1_req = ($urandom_range(0, 99) < 70);
        m1_we = 1'($urandom);
        m1_addr = rand_addr();
        m1_wdata = $urandom;
      end
      rst_n = ($urandom_range(0, 99) >= 3);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
